// File: rtl/image_window_feeder.sv
// Raster frame reader feeding a 3x3 window buffer; pixel at read+2, win_valid at read+2+WIN_LAT.
// No backpressure (stream never stalls). IMAGE_WINDOW_FEEDER_ZERO_PAD_EN adds a zero border.
module image_window_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 8,
   parameter int IMG_H      = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int WIN_LAT    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [ADDR_WIDTH-1:0]       base_addr,
   output logic                        mem_rd_en,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   input  logic [DATA_WIDTH-1:0]       mem_rdata,
   output logic [DATA_WIDTH-1:0]       pix_out,
   output logic                        pix_valid,
   output logic                        win_valid,
   output logic [$clog2(IMG_H+2)-1:0]  win_row,
   output logic [$clog2(IMG_W+2)-1:0]  win_col,
   output logic                        busy,
   output logic                        done
);
   localparam int RW        = $clog2(IMG_H+2);
   localparam int CW        = $clog2(IMG_W+2);
   localparam int DRW       = 3;
   localparam int DRAIN_LEN = 2 + WIN_LAT;
`ifdef IMAGE_WINDOW_FEEDER_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state_q;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  rd_en_q, busy_q, done_q;
   logic [DRW-1:0]        drain_q;
   logic                  last_pos;

   // With padding, the stream is IMG_H x IMG_W including a one-pixel zero ring.
   function automatic logic is_pad(input logic [RW-1:0] r, input logic [CW-1:0] c);
      return PAD_EN && ((r == '0) || (r == RW'(IMG_H-1)) || (c == '0) || (c == CW'(IMG_W-1)));
   endfunction

   always_comb begin
      col_d = col_q + CW'(1);
      row_d = row_q;
      if (col_q == CW'(IMG_W-1)) begin
         col_d = '0;
         row_d = row_q + RW'(1);
      end
   end

   assign last_pos = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drain_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= READ;
                  busy_q  <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
                  addr_q  <= base_addr;
                  rd_en_q <= !is_pad('0, '0);
               end
            end
            READ: begin
               // Stored pixels are contiguous, so the address only advances on real reads.
               if (rd_en_q)
                  addr_q <= addr_q + ADDR_WIDTH'(1);
               if (last_pos) begin
                  state_q <= DRAIN;
                  rd_en_q <= 1'b0;
                  drain_q <= '0;
               end else begin
                  row_q   <= row_d;
                  col_q   <= col_d;
                  rd_en_q <= !is_pad(row_d, col_d);
               end
            end
            DRAIN: begin
               drain_q <= drain_q + DRW'(1);
               if (drain_q == DRW'(DRAIN_LEN-1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   logic                  s1_vld_q, s1_pad_q, s1_win_q;
   logic [RW-1:0]         s1_wrow_q;
   logic [CW-1:0]         s1_wcol_q;
   logic [DATA_WIDTH-1:0] pix_q;
   logic                  pix_vld_q;
   logic [WIN_LAT:0]      wv_q;
   logic [RW-1:0]         wr_q [WIN_LAT+1];
   logic [CW-1:0]         wc_q [WIN_LAT+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_pad_q  <= 1'b0;
         s1_win_q  <= 1'b0;
         s1_wrow_q <= '0;
         s1_wcol_q <= '0;
         pix_q     <= '0;
         pix_vld_q <= 1'b0;
         wv_q      <= '0;
         for (int k = 0; k <= WIN_LAT; k++) begin
            wr_q[k] <= '0;
            wc_q[k] <= '0;
         end
      end else begin
         s1_vld_q  <= (state_q == READ);
         s1_pad_q  <= is_pad(row_q, col_q);
         s1_win_q  <= (state_q == READ) && (row_q >= RW'(2)) && (col_q >= CW'(2));
         s1_wrow_q <= row_q - RW'(2);
         s1_wcol_q <= col_q - CW'(2);
         pix_vld_q <= s1_vld_q;
         if (s1_vld_q)
            pix_q <= s1_pad_q ? '0 : mem_rdata;
         // Final stage only loads on a valid window so coordinates hold between windows.
         wv_q[0] <= s1_win_q;
         if (WIN_LAT > 0 || s1_win_q) begin
            wr_q[0] <= s1_wrow_q;
            wc_q[0] <= s1_wcol_q;
         end
         for (int k = 1; k <= WIN_LAT; k++) begin
            wv_q[k] <= wv_q[k-1];
            if (k < WIN_LAT || wv_q[k-1]) begin
               wr_q[k] <= wr_q[k-1];
               wc_q[k] <= wc_q[k-1];
            end
         end
      end
   end

   assign mem_rd_en = rd_en_q;
   assign mem_addr  = addr_q;
   assign pix_out   = pix_q;
   assign pix_valid = pix_vld_q;
   assign win_valid = wv_q[WIN_LAT];
   assign win_row   = wr_q[WIN_LAT];
   assign win_col   = wc_q[WIN_LAT];
   assign busy      = busy_q;
   assign done      = done_q;
endmodule
